// File: rtl/mem_fetch_port_if.sv
// mem_fetch_port_if: memory, redirect, store and instruction
// stream signals of the fetch port, bundled for the port and its environment.
interface mem_fetch_port_if;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [15:0] inst_addr;
    logic        inst_ready;

    modport master (
        output mem_addr, mem_wdata, mem_we, st_ready,
        output inst_valid, inst_data, inst_addr,
        input  mem_data, jmp_valid, jmp_addr,
        input  st_valid, st_addr, st_data, inst_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, st_ready,
        input  inst_valid, inst_data, inst_addr,
        output mem_data, jmp_valid, jmp_addr,
        output st_valid, st_addr, st_data, inst_ready
    );
endinterface

// File: rtl/mem_fetch_port.sv
// mem_fetch_port: single-port memory arbiter with a prefetch FIFO.
// Optional macro STORE_FLUSH_EN: stores flush the FIFO and refetch.
module mem_fetch_port #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    mem_fetch_port_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    logic [15:0]   pc, pc_nxt;
    logic [31:0]   fdata [DEPTH];
    logic [15:0]   faddr [DEPTH];

    logic jmp, st_acc, full, pop, fetch, flush;

    assign jmp    = bus.jmp_valid;
    assign st_acc = bus.st_valid && !jmp;
    assign full   = (count == CW'(DEPTH));
    assign pop    = bus.inst_valid && bus.inst_ready;
    assign fetch  = !jmp && !st_acc && (!full || pop);

    assign bus.st_ready   = st_acc;
    assign bus.inst_valid = (count != '0) && !jmp;
    assign bus.inst_data  = fdata[rptr];
    assign bus.inst_addr  = faddr[rptr];

    // One memory action per cycle: a store owns the bus, else pc is shown.
    assign bus.mem_addr  = st_acc ? bus.st_addr : pc;
    assign bus.mem_we    = st_acc && rst_n;
    assign bus.mem_wdata = st_acc ? bus.st_data : '0;

    // Next pc and flush decision; jump wins over store over fetch.
    always_comb begin
        pc_nxt = pc;
        flush  = 1'b0;
        if (jmp) begin
            pc_nxt = bus.jmp_addr;
            flush  = 1'b1;
        end else if (st_acc) begin
`ifdef STORE_FLUSH_EN
            flush = 1'b1;
            if (pop) begin
                pc_nxt = (count > CW'(1)) ? faddr[rptr + PW'(1)] : pc;
            end else begin
                pc_nxt = (count != '0) ? faddr[rptr] : pc;
            end
`else
            pc_nxt = pc;
`endif
        end else if (fetch) begin
            pc_nxt = pc + 16'd1;
        end
    end

    // Occupancy after this cycle's fetch and pop.
    always_comb begin
        count_nxt = count;
        if (fetch && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!fetch && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Control state: pc, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            pc <= pc_nxt;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (fetch) wptr <= wptr + PW'(1);
                if (pop)   rptr <= rptr + PW'(1);
                count <= count_nxt;
            end
        end
    end

    // FIFO payload; stale entries are harmless since pointers gate them.
    always_ff @(posedge clk) begin
        if (fetch) begin
            fdata[wptr] <= bus.mem_data;
            faddr[wptr] <= pc;
        end
    end
endmodule

// File: tb/tb_mem_fetch_port.sv
// tb_mem_fetch_port: directed scenarios plus random traffic checked
// against a queue-based model of the fetch port.
module tb_mem_fetch_port;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fetch_port_if bus ();

    mem_fetch_port #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem  [65536];
    logic [31:0] rmem [65536];

    assign bus.mem_data = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mpc;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare at negedge, then advance the model across the posedge.
    task automatic step();
        logic j, st, pop, fetch;
        ent_t e;
        @(negedge clk);
        j  = bus.jmp_valid;
        st = bus.st_valid && !j;
        check("st_ready", 32'(bus.st_ready), 32'(st));
        if (!rst_n) begin
            check("rst_valid", 32'(bus.inst_valid), 32'd0);
            check("rst_we", 32'(bus.mem_we), 32'd0);
            q.delete();
            mpc = '0;
        end else begin
            check("inst_valid", 32'(bus.inst_valid),
                  32'(q.size() != 0 && !j));
            if (q.size() != 0 && !j) begin
                check("inst_addr", 32'(bus.inst_addr), 32'(q[0].a));
                check("inst_data", bus.inst_data, q[0].d);
            end
            check("mem_we", 32'(bus.mem_we), 32'(st));
            check("mem_addr", 32'(bus.mem_addr),
                  32'(st ? bus.st_addr : mpc));
            check("mem_wdata", bus.mem_wdata, st ? bus.st_data : 32'd0);
            if (j) begin
                q.delete();
                mpc = bus.jmp_addr;
            end else begin
                pop   = (q.size() != 0) && bus.inst_ready;
                fetch = !st && (q.size() < DEPTH || pop);
                if (st) rmem[bus.st_addr] = bus.st_data;
                if (pop) void'(q.pop_front());
                if (fetch) begin
                    e.a = mpc;
                    e.d = rmem[mpc];
                    q.push_back(e);
                    mpc = mpc + 16'd1;
                end
`ifdef STORE_FLUSH_EN
                if (st) begin
                    if (q.size() != 0) mpc = q[0].a;
                    q.delete();
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.st_valid  = 1'b0;
        bus.jmp_valid = 1'b0;
        #1;
        check("rst_async", 32'(bus.inst_valid), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 32'(i) + 32'h100;
            rmem[i] = 32'(i) + 32'h100;
        end
        q.delete();
        mpc = '0;
        bus.jmp_valid  = 1'b0;
        bus.jmp_addr   = '0;
        bus.st_valid   = 1'b0;
        bus.st_addr    = '0;
        bus.st_data    = '0;
        bus.inst_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;

        bus.inst_ready = 1'b1;
        repeat (8) step();

        do_reset();
        bus.inst_ready = 1'b0;
        repeat (10) step();
        check("hold_addr", 32'(bus.mem_addr), 32'(DEPTH));
        check("hold_head", 32'(bus.inst_addr), 32'd0);

        bus.jmp_valid = 1'b1;
        bus.jmp_addr  = 16'h0040;
        step();
        bus.jmp_valid  = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (4) step();

        do_reset();
        bus.inst_ready = 1'b0;
        repeat (4) step();
        bus.st_valid = 1'b1;
        bus.st_addr  = 16'h0002;
        bus.st_data  = 32'hDEADBEEF;
        step();
        bus.st_valid   = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (8) step();

        bus.jmp_valid = 1'b1;
        bus.jmp_addr  = 16'hFFFE;
        step();
        bus.jmp_valid = 1'b0;
        repeat (5) step();

        do_reset();
        repeat (4) step();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 1) begin
                do_reset();
                continue;
            end
            bus.jmp_valid = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 2))
                0:       bus.jmp_addr = 16'hFFFE;
                1:       bus.jmp_addr = 16'($urandom_range(0, 63));
                default: bus.jmp_addr = 16'($urandom);
            endcase
            bus.st_valid   = ($urandom_range(0, 99) < 12);
            bus.st_addr    = mpc - 16'($urandom_range(0, 5));
            bus.st_data    = $urandom;
            bus.inst_ready = ($urandom_range(0, 99) < 65);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_fetch_port.md
MEM_FETCH_PORT -- requirements
Module: mem_fetch_port

Interface
REQ-001 Parameter: DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  system clock, all state on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_addr  output  16  word address to memory; memory returns mem_data combinationally in the same cycle.
REQ-005 mem_data  input  32  memory read data for mem_addr.
REQ-006 mem_wdata  output  32  memory write data.
REQ-007 mem_we  output  1  write enable; memory writes mem_wdata at mem_addr on posedge.
REQ-008 jmp_valid  input  1  redirect request, one-cycle pulse or held.
REQ-009 jmp_addr  input  16  redirect target.
REQ-010 st_valid  input  1  store request.
REQ-011 st_addr  input  16  store address.
REQ-012 st_data  input  32  store data.
REQ-013 st_ready  output  1  store accepted this cycle.
REQ-014 inst_valid  output  1  head FIFO word valid.
REQ-015 inst_data  output  32  head word.
REQ-016 inst_addr  output  16  address of head word.
REQ-017 inst_ready  input  1  consumer accepts head word.

Function
REQ-018 Exactly one memory action per cycle, priority: jump (no access) > store > fetch > idle.
REQ-019 st_ready = st_valid && !jmp_valid, combinational; when high: mem_we=1, mem_addr=st_addr, mem_wdata=st_data.
REQ-020 Fetch when no jump, no store accepted, and (count < DEPTH or pop this cycle): mem_addr=pc, mem_we=0; {mem_data, pc} written to FIFO tail at posedge; pc <= pc+1, wrapping 16'hFFFF to 16'h0000.
REQ-021 Idle or jump cycle: mem_addr=pc, mem_we=0, mem_wdata=0.
REQ-022 inst_valid = (count != 0) && !jmp_valid; inst_data/inst_addr from registered head entry; no combinational path from mem_data to inst_*.
REQ-023 Pop when inst_valid && inst_ready; simultaneous pop and fetch leave count unchanged.
REQ-024 Fetch latency: word fetched in cycle N is presented on inst_* in cycle N+1 if FIFO was empty.
REQ-025 Jump: at posedge with jmp_valid=1, FIFO flushed (count=0, pointers equal), pc <= jmp_addr; any pop or store that cycle is not performed.
REQ-026 Full FIFO with no pop: no fetch, pc holds, mem_we=0 unless storing.
REQ-027 Store while FIFO empty or not full: fetch stalls for that cycle only; pc unchanged.

Reset
REQ-028 rst_n low asynchronously sets pc=0, count=0, FIFO pointers=0; mem_we=0, inst_valid=0, st_ready follows REQ-019 (combinational).
REQ-029 Reset mid-fetch or mid-store discards the operation; first fetch after rst_n rises reads address 0.

Configuration
REQ-030 Macro STORE_FLUSH_EN: defined -> every accepted store flushes FIFO and sets pc to the address of the oldest entry not popped that cycle, else to pc (refetch for self-modified code).
REQ-031 STORE_FLUSH_EN undefined -> stores never alter FIFO contents or pc.

Verification
REQ-032 Memory preloaded word[i]=i+0x100, inst_ready=1 after reset -> inst_addr 0,1,2,... with inst_data 0x100,0x101,... one per cycle from cycle 2.
REQ-033 inst_ready=0 for 10 cycles -> exactly DEPTH fetches, then mem_addr holds DEPTH, inst_addr holds 0.
REQ-034 jmp_valid pulse jmp_addr=0x0040 with full FIFO -> inst_valid=0 that cycle, next word inst_addr=0x0040, data 0x140.
REQ-035 st_valid st_addr=0x0002 st_data=0xDEADBEEF while addr 2 queued -> mem_we=1 one cycle, st_ready=1; with STORE_FLUSH_EN consumer later sees addr 2 = 0xDEADBEEF, without it sees 0x102.
REQ-036 jmp_addr=0xFFFE -> inst_addr sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-037 rst_n low for one cycle mid-stream -> inst_valid=0 immediately, refetch from address 0.
